axi2mem_rd_trans_gen: RTL



---
 rtl/axi2mem_pkg.sv | 17 +
 rtl/axi2mem_rd_addr_calc.sv | 48 ++++
 rtl/axi2mem_rd_trans_gen.sv | 112 +++++++++++
 3 files changed

// File: rtl/axi2mem_pkg.sv
// Shared types and constants for the AXI-to-TCDM read/write command generators.
// Lanes are 32 bits wide and cover the 64-bit AXI data bus.
package axi2mem_pkg;

  localparam int AXI_DATA_BYTES = 8;
  localparam int LANES          = 2;
  localparam int LANE_BYTES     = 4;

  typedef logic [2:0] size_t;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

endpackage

// File: rtl/axi2mem_rd_addr_calc.sv
// Combinational AXI beat address stepper and byte-lane mask generator.
// The mask starts at the (possibly unaligned) address and ends at the aligned beat end.
module axi2mem_rd_addr_calc
  import axi2mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]     addr,
  input  size_t                     size,
  input  logic [7:0]                len,
  input  logic [1:0]                burst,
  output logic [ADDR_WIDTH-1:0]     next_addr,
  output logic [AXI_DATA_BYTES-1:0] byte_mask
);

  logic [2:0]            size_eff;
  logic [ADDR_WIDTH-1:0] nbytes;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] span;
  logic [ADDR_WIDTH-1:0] wrap_base;
  logic [3:0]            start_off;
  logic [3:0]            end_off;

  always_comb begin
    size_eff  = (size > 3'd3) ? 3'd3 : size;
    nbytes    = ADDR_WIDTH'(1) << size_eff;
    aligned   = addr & ~(nbytes - ADDR_WIDTH'(1));
    incr_addr = aligned + nbytes;
    span      = nbytes * (ADDR_WIDTH'(len) + ADDR_WIDTH'(1));
    wrap_base = addr & ~(span - ADDR_WIDTH'(1));

    // Reserved burst encoding falls through to INCR.
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = wrap_base | (incr_addr & (span - ADDR_WIDTH'(1)));
      default:     next_addr = incr_addr;
    endcase

    start_off = {1'b0, addr[2:0]};
    end_off   = {1'b0, aligned[2:0]} + nbytes[3:0] - 4'd1;
    byte_mask = '0;
    for (int i = 0; i < AXI_DATA_BYTES; i++) begin
      byte_mask[i] = (4'(i) >= start_off) && (4'(i) <= end_off);
    end
  end

endmodule

// File: rtl/axi2mem_rd_trans_gen.sv
// Expands one AXI4 read burst into per-beat TCDM read commands on two 32-bit lanes.
// Lanes handshake independently but a beat only advances once both have been granted.
module axi2mem_rd_trans_gen
  import axi2mem_pkg::*;
#(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [ID_WIDTH-1:0]            ar_id_i,
  input  logic [ADDR_WIDTH-1:0]          ar_addr_i,
  input  logic [7:0]                     ar_len_i,
  input  logic [2:0]                     ar_size_i,
  input  logic [1:0]                     ar_burst_i,
  input  logic                           ar_valid_i,
  output logic                           ar_ready_o,
  output logic [1:0]                     trans_rd_req_o,
  output logic [1:0][ADDR_WIDTH-1:0]     trans_rd_add_o,
  output logic [1:0][3:0]                trans_rd_be_o,
  output logic [1:0][ID_WIDTH-1:0]       trans_rd_id_o,
  output logic [1:0]                     trans_rd_last_o,
  input  logic [1:0]                     trans_rd_gnt_i
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                    state;
  logic [ID_WIDTH-1:0]       id_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [7:0]                len_q;
  logic [7:0]                beat_cnt;
  size_t                     size_q;
  logic [1:0]                burst_q;
  logic [LANES-1:0]          done_q;
  logic [LANES-1:0]          req;
  logic [LANES-1:0]          lane_done;
  logic [ADDR_WIDTH-1:0]     next_addr;
  logic [AXI_DATA_BYTES-1:0] byte_mask;
  logic                      issue;
  logic                      last;

  axi2mem_rd_addr_calc #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) i_addr_calc (
    .addr      (addr_q),
    .size      (size_q),
    .len       (len_q),
    .burst     (burst_q),
    .next_addr (next_addr),
    .byte_mask (byte_mask)
  );

  assign issue     = (state == ISSUE);
  assign last      = (beat_cnt == len_q);
  assign req       = issue ? ~done_q : '0;
  assign lane_done = done_q | (req & trans_rd_gnt_i);

  assign ar_ready_o        = (state == IDLE);
  assign trans_rd_req_o    = req;
  assign trans_rd_add_o[0] = issue ? {addr_q[ADDR_WIDTH-1:3], 3'b000} : '0;
  assign trans_rd_add_o[1] = issue ? {addr_q[ADDR_WIDTH-1:3], 3'b100} : '0;
  assign trans_rd_be_o[0]  = issue ? byte_mask[LANE_BYTES-1:0] : '0;
  assign trans_rd_be_o[1]  = issue ? byte_mask[2*LANE_BYTES-1:LANE_BYTES] : '0;
  assign trans_rd_id_o[0]  = issue ? id_q : '0;
  assign trans_rd_id_o[1]  = issue ? id_q : '0;
  assign trans_rd_last_o   = (issue && last) ? 2'b11 : 2'b00;

  // A granted lane parks in done_q until its partner is granted too.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      done_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_valid_i) begin
            id_q     <= ar_id_i;
            addr_q   <= ar_addr_i;
            len_q    <= ar_len_i;
            size_q   <= ar_size_i;
            burst_q  <= ar_burst_i;
            beat_cnt <= '0;
            done_q   <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (&lane_done) begin
            done_q <= '0;
            if (last) begin
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
              addr_q   <= next_addr;
            end
          end else begin
            done_q <= lane_done;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
